pipeline_register: RTL and testbench

//  Generic single-stage pipeline register between core stages (IF/ID, ID/EX, ...).

---
 rtl/pipeline_register.sv | 89 ++++++++
 tb/tb_pipeline_register.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pipeline_register.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_register
// Purpose  : Single-stage pipeline register placed between core stages
//            (IF/ID, ID/EX, ...). Captures pipe_input on every rising edge,
//            holds its value while stalled, and loads a caller-supplied
//            bubble word (typically a NOP) on flush. Flush beats stall.
//            A simulation-only scan port dumps the stage state inside a
//            programmable cycle window.
//
// Ports    : clock        in   1           rising-edge clock
//            reset        in   1           asynchronous, active-low reset
//            stall        in   1           1 = hold current output
//            flush        in   1           1 = load flush_input (bubble)
//            pipe_input   in   PIPE_WIDTH  data from the previous stage
//            flush_input  in   PIPE_WIDTH  bubble word loaded on flush
//            pipe_output  out  PIPE_WIDTH  registered data to next stage
//            scan         in   1           1 = enable simulation state dump
//
// Revision : 1.0  initial release
// ============================================================================
module pipeline_register #(
  parameter int          PIPELINE_STAGE  = 0,
  parameter int          PIPE_WIDTH      = 32,
  parameter int unsigned SCAN_CYCLES_MIN = 1,
  parameter int unsigned SCAN_CYCLES_MAX = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [PIPE_WIDTH-1:0] pipe_input,
  input  logic [PIPE_WIDTH-1:0] flush_input,
  output logic [PIPE_WIDTH-1:0] pipe_output,
  input  logic                  scan
);

  logic [PIPE_WIDTH-1:0] r_pipe_data;

  // Next-value selection; flush has priority so a squashed stage always
  // receives a bubble, even if the downstream logic is also stalling it.
  logic [PIPE_WIDTH-1:0] w_pipe_next;

  always_comb begin
    w_pipe_next = r_pipe_data;
    if (flush) begin
      w_pipe_next = flush_input;
    end else if (!stall) begin
      w_pipe_next = pipe_input;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pipe_data <= '0;
    end else begin
      r_pipe_data <= w_pipe_next;
    end
  end

  // Output comes straight from the flop: no combinational input-to-output path.
  assign pipe_output = r_pipe_data;

`ifndef SYNTHESIS
  // Debug-only cycle counter and state dump. Neither feeds the datapath.
  logic [31:0] r_cycle_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle_count <= 32'd0;
    end else begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  // The dump reports the counter value seen at this edge, before it advances.
  always_ff @(posedge clock) begin
    if (reset && scan &&
        (r_cycle_count >= SCAN_CYCLES_MIN) &&
        (r_cycle_count <= SCAN_CYCLES_MAX)) begin
      $display("[scan] stage=%0d cycle=%0d stall=%b flush=%b in=%h flush_in=%h out=%h",
               PIPELINE_STAGE, r_cycle_count, stall, flush,
               pipe_input, flush_input, r_pipe_data);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_register
// Purpose  : Directed self-checking bench for pipeline_register. Covers
//            asynchronous reset, streaming, stall, flush, flush+stall
//            priority, reset during stall/flush, and scan transparency.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_register;

  localparam int c_width = 32;

  logic               clock;
  logic               reset;
  logic               stall;
  logic               flush;
  logic [c_width-1:0] pipe_input;
  logic [c_width-1:0] flush_input;
  logic [c_width-1:0] pipe_output;
  logic               scan;

  int checks = 0;
  int errors = 0;

  pipeline_register #(
    .PIPELINE_STAGE  (2),
    .PIPE_WIDTH      (c_width),
    .SCAN_CYCLES_MIN (1),
    .SCAN_CYCLES_MAX (30)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .pipe_input  (pipe_input),
    .flush_input (flush_input),
    .pipe_output (pipe_output),
    .scan        (scan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [c_width-1:0] expected);
    checks++;
    assert (pipe_output === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, pipe_output, expected);
    end
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    scan        = 1'b0;
    pipe_input  = 32'h0000_0007;
    flush_input = 32'h0000_0013;

    // Capture a non-zero value so the reset drop is observable.
    tick();
    check("pre_reset_capture", 32'h0000_0007);

    // Assert reset between edges: output must clear without a clock edge.
    #2 reset = 1'b0;
    #1 check("reset_async_drop", 32'h0000_0000);

    // Hold reset 4 cycles with pipe_input=1; inputs must be ignored.
    pipe_input = 32'h0000_0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("reset_hold", 32'h0000_0000);
    end

    // Release between edges; first edge after release is a normal update.
    #2 reset = 1'b1;

    // Stream 1..5.
    pipe_input = 32'h0000_0001; tick(); check("stream_1", 32'h0000_0001);
    pipe_input = 32'h0000_0002; tick(); check("stream_2", 32'h0000_0002);
    pipe_input = 32'h0000_0003; tick(); check("stream_3", 32'h0000_0003);
    pipe_input = 32'h0000_0004; tick(); check("stream_4", 32'h0000_0004);
    pipe_input = 32'h0000_0005; tick(); check("stream_5", 32'h0000_0005);

    // One-cycle stall: holds 5; the held input 6 appears on the next edge.
    pipe_input = 32'h0000_0006; stall = 1'b1; tick(); check("stall_hold", 32'h0000_0005);
    stall = 1'b0;               tick(); check("stall_release", 32'h0000_0006);
    pipe_input = 32'h0000_0007; tick(); check("stall_resume", 32'h0000_0007);

    // Flush inserts the NOP bubble, then streaming resumes.
    pipe_input = 32'h0000_0008; flush_input = 32'h0000_0013; flush = 1'b1;
    tick(); check("flush_bubble", 32'h0000_0013);
    flush = 1'b0; pipe_input = 32'h0000_0009;
    tick(); check("flush_resume", 32'h0000_0009);

    // Flush and stall together: flush wins.
    pipe_input = 32'h0000_000A; flush_input = 32'hDEAD_BEEF; flush = 1'b1; stall = 1'b1;
    tick(); check("flush_beats_stall", 32'hDEAD_BEEF);
    // Stall alone now holds the bubble.
    flush = 1'b0; pipe_input = 32'h0000_000B;
    tick(); check("stall_holds_bubble", 32'hDEAD_BEEF);
    stall = 1'b0; pipe_input = 32'h0000_000C;
    tick(); check("after_flush_stall", 32'h0000_000C);

    // Width boundary: all-ones and all-zeros data.
    pipe_input = 32'hFFFF_FFFF; tick(); check("all_ones", 32'hFFFF_FFFF);
    pipe_input = 32'h0000_0000; tick(); check("all_zeros", 32'h0000_0000);

    // Reset asserted mid-stall/mid-flush between edges: reset wins at once.
    pipe_input = 32'h1234_5678; tick(); check("pre_reset2", 32'h1234_5678);
    stall = 1'b1; flush = 1'b1; flush_input = 32'h0000_0013;
    #2 reset = 1'b0;
    #1 check("reset_mid_flush_stall", 32'h0000_0000);
    tick(); check("reset_mid_hold", 32'h0000_0000);
    #2 reset = 1'b1; stall = 1'b0; flush = 1'b0;

    // Scan enabled: datapath behaviour is unchanged (dumps print while the
    // counter is inside the configured window).
    scan = 1'b1;
    pipe_input = 32'h0000_00A5; tick(); check("scan_stream_a5", 32'h0000_00A5);
    pipe_input = 32'h0000_005A; tick(); check("scan_stream_5a", 32'h0000_005A);
    stall = 1'b1; pipe_input = 32'h0000_0077;
    tick(); check("scan_stall", 32'h0000_005A);
    stall = 1'b0; scan = 1'b0;
    tick(); check("scan_off_stream", 32'h0000_0077);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
